// File: rtl/dmem_mmio_bus.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dmem_mmio_bus
// Data-side memory subsystem behind the MEM stage. Decodes each access into
// the data RAM (byte/halfword lanes with sign/zero extension) or a small block
// of memory-mapped registers: LED, free-running timer with compare flag, and
// a UART transmitter fed by a byte FIFO. Loads are combinational; stores
// commit at the rising clock edge.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   mem_w      write strobe for this cycle's access
//   dm_type    000 word, 001 half signed, 010 half unsigned,
//              011 byte signed, 100 byte unsigned
//   addr       byte address
//   wdata      store data, right-aligned
//   rdata      load data (combinational from addr/dm_type)
//   led        LED register
//   uart_tx    serial output, idle high
//   timer_irq  timer match flag
//   bus_err    sticky flag for misaligned or unmapped accesses
// -----------------------------------------------------------------------------
module dmem_mmio_bus #(
  parameter int DM_WORDS   = 1024,
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_w,
  input  logic [2:0]  dm_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [15:0] led,
  output logic        uart_tx,
  output logic        timer_irq,
  output logic        bus_err
);

  localparam int AW = $clog2(DM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(BAUD_DIV);

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF_S = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE_S = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  localparam logic [31:0] MMIO_BASE = 32'h1000_0000;
  localparam logic [2:0]  R_LED     = 3'd0;
  localparam logic [2:0]  R_TCOUNT  = 3'd1;
  localparam logic [2:0]  R_TCMP    = 3'd2;
  localparam logic [2:0]  R_TSTAT   = 3'd3;
  localparam logic [2:0]  R_TXDATA  = 3'd4;
  localparam logic [2:0]  R_USTAT   = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  // ---------------------------------------------------------------------------
  // Address decode and alignment
  // ---------------------------------------------------------------------------
  logic       is_word, is_half, is_byte;
  logic       ram_sel, mmio_sel, mapped, misaligned, access_ok, wr_ok;
  logic [2:0] reg_idx;

  assign is_word  = (dm_type == DM_WORD);
  assign is_half  = (dm_type == DM_HALF_S) || (dm_type == DM_HALF_U);
  assign is_byte  = (dm_type == DM_BYTE_S) || (dm_type == DM_BYTE_U);
  assign reg_idx  = addr[4:2];
  assign ram_sel  = (addr[31:AW+2] == '0);
  assign mmio_sel = (addr[31:5] == MMIO_BASE[31:5]) && (reg_idx <= R_USTAT);
  assign mapped   = ram_sel || mmio_sel;

  // Undefined dm_type encodings are rejected like a misaligned access.
  // MMIO registers only accept aligned word accesses.
  assign misaligned =
      (ram_sel  && ((is_word && (addr[1:0] != 2'b00)) || (is_half && addr[0]) ||
                    !(is_word || is_half || is_byte))) ||
      (mmio_sel && (!is_word || (addr[1:0] != 2'b00)));

  assign access_ok = mapped && !misaligned;
  assign wr_ok     = mem_w && access_ok;

  // Misalignment only arises inside a mapped region, so it flags even on a
  // plain read. Unmapped addresses flag only on stores, because the core
  // drives addr every cycle whether or not it is loading.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent logic.
    if (reset)
      bus_err <= 1'b0;
    else if (misaligned || (!mapped && mem_w))
      bus_err <= 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Data RAM
  // ---------------------------------------------------------------------------
  logic [31:0]   ram [DM_WORDS];
  logic [AW-1:0] word_idx;
  logic [31:0]   ram_word, ram_load, store_data;
  logic [15:0]   half_lane;
  logic [7:0]    byte_lane;
  logic [3:0]    byte_en;

  assign word_idx  = addr[AW+1:2];
  assign ram_word  = ram[word_idx];
  assign half_lane = addr[1] ? ram_word[31:16] : ram_word[15:0];
  assign byte_lane = ram_word[{addr[1:0], 3'b000} +: 8];

  // Replicate the store value across lanes; byte_en picks the target lane.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    byte_en    = 4'b0000;
    store_data = wdata;
    if (is_word) begin
      byte_en = 4'b1111;
    end else if (is_half) begin
      byte_en    = addr[1] ? 4'b1100 : 4'b0011;
      store_data = {2{wdata[15:0]}};
    end else if (is_byte) begin
      byte_en    = 4'b0001 << addr[1:0];
      store_data = {4{wdata[7:0]}};
    end
  end

  // NOTE: the RAM array has no reset; clearing it would force flops in place
  // of a memory macro, and software must not rely on its power-up contents.
  always_ff @(posedge clk) begin
    if (wr_ok && ram_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) ram[word_idx][8*i +: 8] <= store_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    ram_load = '0;
    case (dm_type)
      DM_WORD:   ram_load = ram_word;
      DM_HALF_S: ram_load = {{16{half_lane[15]}}, half_lane};
      DM_HALF_U: ram_load = {16'h0000, half_lane};
      DM_BYTE_S: ram_load = {{24{byte_lane[7]}}, byte_lane};
      DM_BYTE_U: ram_load = {24'h00_0000, byte_lane};
      default:   ram_load = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // MMIO register writes
  // ---------------------------------------------------------------------------
  logic        mmio_we;
  logic [31:0] tcount, tcmp;
  logic        tflag;

  assign mmio_we   = wr_ok && mmio_sel;
  assign timer_irq = tflag;

  always_ff @(posedge clk) begin
    if (reset)
      led <= '0;
    else if (mmio_we && reg_idx == R_LED)
      led <= wdata[15:0];
  end

  // The match flag compares the pre-edge count, so it rises one edge after
  // count==tcmp. A same-cycle W1C loses to a new match.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcount <= '0;
      tcmp   <= 32'hFFFF_FFFF;
      tflag  <= 1'b0;
    end else begin
      if (mmio_we && reg_idx == R_TCOUNT) tcount <= wdata;
      else                                tcount <= tcount + 32'd1;
      if (mmio_we && reg_idx == R_TCMP)   tcmp   <= wdata;
      if (tcount == tcmp)                              tflag <= 1'b1;
      else if (mmio_we && reg_idx == R_TSTAT && wdata[0]) tflag <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // UART TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_full, fifo_empty, push_req, push, pop, overflow;

  assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign push_req   = mmio_we && (reg_idx == R_TXDATA);
  // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
  assign push       = push_req && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push_req && !push)                   overflow <= 1'b1;
      else if (mmio_we && reg_idx == R_USTAT)  overflow <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // UART serialiser: start bit, 8 data bits LSB first, stop bit
  // ---------------------------------------------------------------------------
  uart_state_t   state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shifter;
  logic          baud_last, busy;

  assign baud_last = (baud_cnt == BW'(BAUD_DIV - 1));
  assign busy      = (state != S_IDLE);
  // Loading straight from STOP keeps consecutive frames gap-free.
  assign pop       = !fifo_empty &&
                     ((state == S_IDLE) || (state == S_STOP && baud_last));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      uart_tx  <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shifter  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            state    <= S_START;
            shifter  <= fifo_mem[rd_ptr];
            uart_tx  <= 1'b0;
            baud_cnt <= '0;
          end
        end
        S_START: begin
          if (baud_last) begin
            state    <= S_DATA;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            uart_tx  <= shifter[0];
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        S_DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state   <= S_STOP;
              uart_tx <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shifter <= shifter >> 1;
              uart_tx <= shifter[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        S_STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (!fifo_empty) begin
              state   <= S_START;
              shifter <= fifo_mem[rd_ptr];
              uart_tx <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Load data mux
  // ---------------------------------------------------------------------------
  logic [31:0] mmio_rd;

  always_comb begin
    mmio_rd = '0;
    case (reg_idx)
      R_LED:    mmio_rd = {16'h0000, led};
      R_TCOUNT: mmio_rd = tcount;
      R_TCMP:   mmio_rd = tcmp;
      R_TSTAT:  mmio_rd = {31'h0, tflag};
      R_USTAT:  mmio_rd = {28'h0, overflow, busy, fifo_empty, fifo_full};
      default:  mmio_rd = '0;
    endcase
  end

  assign rdata = !access_ok ? 32'h0 : (ram_sel ? ram_load : mmio_rd);

endmodule

// File: tb/tb_dmem_mmio_bus.sv
`timescale 1ns/1ps
// Directed testbench for dmem_mmio_bus (BAUD_DIV=4, FIFO_DEPTH=4).
module tb_dmem_mmio_bus;

  localparam logic [31:0] A_LED    = 32'h1000_0000;
  localparam logic [31:0] A_TCOUNT = 32'h1000_0004;
  localparam logic [31:0] A_TCMP   = 32'h1000_0008;
  localparam logic [31:0] A_TSTAT  = 32'h1000_000C;
  localparam logic [31:0] A_TXDATA = 32'h1000_0010;
  localparam logic [31:0] A_USTAT  = 32'h1000_0014;
  localparam logic [2:0]  T_W  = 3'b000;
  localparam logic [2:0]  T_HS = 3'b001;
  localparam logic [2:0]  T_HU = 3'b010;
  localparam logic [2:0]  T_BS = 3'b011;
  localparam logic [2:0]  T_BU = 3'b100;

  logic        clk;
  logic        reset;
  logic        mem_w;
  logic [2:0]  dm_type;
  logic [31:0] addr, wdata, rdata;
  logic [15:0] led;
  logic        uart_tx, timer_irq, bus_err;

  int checks = 0;
  int errors = 0;

  dmem_mmio_bus #(.DM_WORDS(1024), .BAUD_DIV(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .mem_w(mem_w), .dm_type(dm_type), .addr(addr),
    .wdata(wdata), .rdata(rdata), .led(led), .uart_tx(uart_tx),
    .timer_irq(timer_irq), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    mem_w = 1'b0; addr = 32'h0; dm_type = T_W; wdata = 32'h0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [2:0] t, input logic [31:0] d);
    addr = a; dm_type = t; wdata = d; mem_w = 1'b1;
    tick();
    bus_idle();
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [2:0] t, output logic [31:0] d);
    mem_w = 1'b0; addr = a; dm_type = t;
    #1;
    d = rdata;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus_idle();
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return b[j-1];
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    checks++; if (led !== 16'h0) begin errors++; $display("FAIL reset_led: got %h expected 0000", led); end
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_uart_tx: got %b expected 1", uart_tx); end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", timer_irq); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err: got %b expected 0", bus_err); end
    bus_read(A_TCOUNT, T_W, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_tcount: got %h expected 00000000", d); end
    bus_read(A_TCMP, T_W, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_tcmp: got %h expected ffffffff", d); end
    bus_read(A_USTAT, T_W, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL reset_ustat: got %h expected 00000002", d); end
    bus_idle();
  endtask

  task automatic test_store_byte();
    logic [31:0] d;
    bus_write(32'h40, T_W, 32'h1122_3344);
    bus_write(32'h41, T_BS, 32'h1234_56AA);
    bus_read(32'h40, T_W, d);
    checks++; if (d !== 32'h1122_AA44) begin errors++; $display("FAIL sb_lw: got %h expected 1122aa44", d); end
    bus_read(32'h41, T_BS, d);
    checks++; if (d !== 32'hFFFF_FFAA) begin errors++; $display("FAIL sb_lb: got %h expected ffffffaa", d); end
    bus_read(32'h41, T_BU, d);
    checks++; if (d !== 32'h0000_00AA) begin errors++; $display("FAIL sb_lbu: got %h expected 000000aa", d); end
    bus_read(32'h42, T_HS, d);
    checks++; if (d !== 32'h0000_1122) begin errors++; $display("FAIL sb_lh: got %h expected 00001122", d); end
    bus_write(32'h44, T_W, 32'hDEAD_BEEF);
    bus_write(32'h46, T_HU, 32'hCAFE_8001);
    bus_read(32'h44, T_W, d);
    checks++; if (d !== 32'h8001_BEEF) begin errors++; $display("FAIL sh_lw: got %h expected 8001beef", d); end
    bus_read(32'h46, T_HS, d);
    checks++; if (d !== 32'hFFFF_8001) begin errors++; $display("FAIL sh_lh: got %h expected ffff8001", d); end
    bus_read(32'h46, T_HU, d);
    checks++; if (d !== 32'h0000_8001) begin errors++; $display("FAIL sh_lhu: got %h expected 00008001", d); end
    bus_idle();
    tick();
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL ram_no_err: got %b expected 0", bus_err); end
  endtask

  task automatic test_led();
    logic [31:0] d;
    bus_write(A_LED, T_W, 32'h1234_ABCD);
    checks++; if (led !== 16'hABCD) begin errors++; $display("FAIL led_port: got %h expected abcd", led); end
    bus_read(A_LED, T_W, d);
    checks++; if (d !== 32'h0000_ABCD) begin errors++; $display("FAIL led_read: got %h expected 0000abcd", d); end
    bus_idle();
  endtask

  task automatic test_timer();
    logic [31:0] d;
    int rise;
    bus_write(A_TCOUNT, T_W, 32'd10);
    bus_write(A_TCMP, T_W, 32'd15);
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL timer_early: got %b expected 0", timer_irq); end
    rise = -1;
    for (int k = 2; k <= 8; k++) begin
      tick();
      if (timer_irq === 1'b1 && rise < 0) rise = k;
    end
    checks++; if (rise != 6) begin errors++; $display("FAIL timer_rise_edge: got %0d expected 6", rise); end
    bus_write(A_TSTAT, T_W, 32'h1);
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL timer_w1c: got %b expected 0", timer_irq); end
    bus_read(A_TSTAT, T_W, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL tstat_read: got %h expected 00000000", d); end
    bus_write(A_TCOUNT, T_W, 32'd100);
    bus_write(A_TCMP, T_W, 32'd101);
    bus_write(A_TSTAT, T_W, 32'h1);
    checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL timer_set_wins: got %b expected 1", timer_irq); end
    bus_write(A_TSTAT, T_W, 32'h1);
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL timer_clear2: got %b expected 0", timer_irq); end
    bus_write(A_TCMP, T_W, 32'h8000_0000);
    bus_read(A_TCMP, T_W, d);
    checks++; if (d !== 32'h8000_0000) begin errors++; $display("FAIL tcmp_read: got %h expected 80000000", d); end
    bus_write(A_TCOUNT, T_W, 32'hFFFF_FFFE);
    bus_read(A_TCOUNT, T_W, d);
    checks++; if (d !== 32'hFFFF_FFFE) begin errors++; $display("FAIL tcount_load: got %h expected fffffffe", d); end
    tick();
    bus_read(A_TCOUNT, T_W, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL tcount_max: got %h expected ffffffff", d); end
    tick();
    bus_read(A_TCOUNT, T_W, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL tcount_wrap: got %h expected 00000000", d); end
    bus_idle();
  endtask

  task automatic test_uart();
    int bad_bits, busy_cycles;
    addr = A_TXDATA; dm_type = T_W; wdata = 32'h55; mem_w = 1'b1;
    tick();
    mem_w = 1'b0; addr = A_USTAT;
    bad_bits = 0; busy_cycles = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (uart_tx !== frame_bit(8'h55, (k - 1) / 4)) bad_bits++;
      if (rdata[2] === 1'b1) busy_cycles++;
    end
    checks++; if (bad_bits != 0) begin errors++; $display("FAIL uart_frame_55: got %0d wrong samples expected 0", bad_bits); end
    checks++; if (busy_cycles != 40) begin errors++; $display("FAIL uart_busy_len: got %0d expected 40", busy_cycles); end
    tick();
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL uart_idle_after: got %b expected 1", uart_tx); end
    checks++; if (rdata !== 32'h2) begin errors++; $display("FAIL uart_ustat_after: got %h expected 00000002", rdata); end
    bus_idle();
  endtask

  task automatic test_fifo();
    logic [7:0] tx_bytes [6];
    logic       samp [202];
    int         bad;
    tx_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    for (int k = 0; k < 6; k++) begin
      addr = A_TXDATA; dm_type = T_W; wdata = {24'h0, tx_bytes[k]}; mem_w = 1'b1;
      tick();
      samp[k] = uart_tx;
    end
    mem_w = 1'b0; addr = A_USTAT;
    #1;
    checks++; if (rdata !== 32'hD) begin errors++; $display("FAIL fifo_ustat_ovf: got %h expected 0000000d", rdata); end
    mem_w = 1'b1; wdata = 32'h0;
    tick();
    samp[6] = uart_tx;
    mem_w = 1'b0;
    #1;
    checks++; if (rdata !== 32'h5) begin errors++; $display("FAIL fifo_ustat_clr: got %h expected 00000005", rdata); end
    for (int k = 7; k <= 200; k++) begin
      tick();
      samp[k] = uart_tx;
    end
    for (int f = 0; f < 5; f++) begin
      bad = 0;
      for (int k = 1 + 40 * f; k <= 40 + 40 * f; k++)
        if (samp[k] !== frame_bit(tx_bytes[f], ((k - 1) % 40) / 4)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL fifo_frame%0d: got %0d wrong samples expected 0", f, bad); end
    end
    tick();
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL fifo_idle_after: got %b expected 1", uart_tx); end
    checks++; if (rdata !== 32'h2) begin errors++; $display("FAIL fifo_ustat_end: got %h expected 00000002", rdata); end
    bus_idle();
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    bus_read(32'h2000_0000, T_W, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h expected 00000000", d); end
    bus_read(32'h0000_1000, T_W, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL past_ram_read: got %h expected 00000000", d); end
    bus_read(32'h1000_0018, T_W, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL past_mmio_read: got %h expected 00000000", d); end
    tick();
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL unmapped_read_err: got %b expected 0", bus_err); end
    bus_write(32'h2000_0000, T_W, 32'h1);
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL unmapped_write_err: got %b expected 1", bus_err); end
  endtask

  task automatic test_misaligned();
    logic [31:0] d;
    do_reset();
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL mis_pre_err: got %b expected 0", bus_err); end
    bus_read(32'h42, T_W, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mis_lw_data: got %h expected 00000000", d); end
    tick();
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL mis_lw_err: got %b expected 1", bus_err); end
    bus_write(32'h43, T_HU, 32'hFFFF_FFFF);
    bus_read(32'h40, T_W, d);
    checks++; if (d !== 32'h1122_AA44) begin errors++; $display("FAIL mis_sh_kept: got %h expected 1122aa44", d); end
    bus_write(A_LED, T_W, 32'h5A5A);
    bus_read(A_LED, T_BU, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mis_mmio_byte: got %h expected 00000000", d); end
    bus_write(32'h1000_0002, T_W, 32'hFFFF);
    checks++; if (led !== 16'h5A5A) begin errors++; $display("FAIL mis_mmio_write: got %h expected 5a5a", led); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d;
    int lows;
    bus_write(A_LED, T_W, 32'hBEEF);
    bus_write(A_TXDATA, T_W, 32'h3C);
    bus_write(A_TXDATA, T_W, 32'hC3);
    repeat (10) tick();
    bus_read(A_USTAT, T_W, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL mid_pre_ustat: got %h expected 00000004", d); end
    reset = 1'b1;
    bus_idle();
    tick();
    reset = 1'b0;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL mid_uart_tx: got %b expected 1", uart_tx); end
    checks++; if (led !== 16'h0) begin errors++; $display("FAIL mid_led: got %h expected 0000", led); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL mid_bus_err: got %b expected 0", bus_err); end
    bus_read(A_TCOUNT, T_W, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_tcount: got %h expected 00000000", d); end
    bus_read(A_USTAT, T_W, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL mid_ustat: got %h expected 00000002", d); end
    bus_idle();
    lows = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (uart_tx !== 1'b1) lows++;
    end
    checks++; if (lows != 0) begin errors++; $display("FAIL mid_line_idle: got %0d low samples expected 0", lows); end
  endtask

  initial begin
    reset = 1'b1;
    bus_idle();
    test_reset();
    test_store_byte();
    test_led();
    test_timer();
    test_uart();
    test_fifo();
    test_unmapped();
    test_misaligned();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
